// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encodings and word geometry.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Byte packer: places incoming bytes little-endian into a 32-bit word.
// word_valid pulses (combinationally) on the transfer that completes a word;
// word_o then already contains that final byte.
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_o,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // Next byte position and word contents
  always_comb begin
    cnt_d      = cnt_q;
    word_d     = word_q;
    word_valid = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_data;
      cnt_d                        = cnt_q + 2'd1;
      word_valid                   = (cnt_q == LAST_BYTE);
    end
  end

  // Counter and word registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_d;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a byte stream, packs it into 32-bit words, writes them
// to instruction memory and releases the core from reset when the load is done.
// Optional trailing-checksum verification is enabled by defining BOOT_CHECKSUM_EN.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  accept;
  logic                  byte_fire;
  logic                  pack_clear;
  logic [31:0]           pack_word;
  logic                  pack_word_valid;

  assign accept    = in_valid && in_ready_q;
  assign byte_fire = accept && (state_q == ST_RECV);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (byte_fire),
    .byte_data  (in_data),
    .word_o     (pack_word),
    .word_valid (pack_word_valid)
  );

  // Next-state logic; outputs are registered from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;
    pack_clear   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d       = csum_q;
    if (byte_fire) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
`ifdef BOOT_CHECKSUM_EN
            csum_d  = '0;
            state_d = ST_CHECK;
`else
            state_d = ST_RUN;
`endif
          end else if (word_count > MAX_WORDS) begin
            error_d = 1'b1;
          end else begin
            count_d    = word_count;
            word_idx_d = '0;
            error_d    = 1'b0;
            pack_clear = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (pack_word_valid) begin
          imem_wdata_d = pack_word;
          imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + ONE;
        if (word_idx_d == count_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RUN;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = ST_RUN;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    in_ready_d   = (state_d == ST_RECV) || (state_d == ST_CHECK);
    imem_we_d    = (state_d == ST_WRITE);
    core_reset_d = (state_d != ST_RUN);
    done_d       = (state_d == ST_RUN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader. Define BOOT_CHECKSUM_EN to exercise
// the trailing-checksum build.
module tb_boot_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned ready_during_we = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int unsigned   wr_cyc[$];

  boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      if (in_ready) ready_during_we++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(output int unsigned at_cyc);
    int unsigned n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    at_cyc = cyc;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    int unsigned done_cyc;
    logic [7:0] prog[8];
    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_we",         32'(imem_we),    32'd0);
    check("rst_addr",       32'(imem_addr),  32'd0);
    check("rst_wdata",      imem_wdata,      32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    reset = 1'b0;
    clear_log();

    // Back-to-back two-word load
    do_start(9'd2);
    check("t1_ready_after_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hC0);
`endif
    wait_done(done_cyc);
    check("t1_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0",  32'(wr_addr[0]), 32'd0);
      check("t1_data0",  wr_data[0],      32'h00500013);
      check("t1_addr1",  32'(wr_addr[1]), 32'd1);
      check("t1_data1",  wr_data[1],      32'h00100093);
`ifndef BOOT_CHECKSUM_EN
      check("t1_done_timing", done_cyc, wr_cyc[1] + 1);
`endif
    end
    check("t1_core_reset", 32'(core_reset), 32'd0);
    check("t1_ready_in_write", ready_during_we, 32'd0);

    // start in RUN is ignored
    clear_log();
    do_start(9'd1);
    repeat (8) @(negedge clk);
    check("run_start_done",   32'(done),       32'd1);
    check("run_start_creset", 32'(core_reset), 32'd0);
    check("run_start_ready",  32'(in_ready),   32'd0);
    check("run_start_writes", 32'(wr_addr.size()), 32'd0);

    // Same load with a 3-cycle stall and a stray start mid-word
    apply_reset();
    do_start(9'd2);
    send_byte(prog[0]);
    send_byte(prog[1]);
    for (int i = 0; i < 3; i++) check("t2_ready_stall", 32'(in_ready), 32'd1);
    repeat (3) begin
      check("t2_ready_stall", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    do_start(9'd1);
    for (int i = 2; i < 8; i++) send_byte(prog[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'hC0);
`endif
    wait_done(done_cyc);
    check("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t2_addr0", 32'(wr_addr[0]), 32'd0);
      check("t2_data0", wr_data[0],      32'h00500013);
      check("t2_addr1", 32'(wr_addr[1]), 32'd1);
      check("t2_data1", wr_data[1],      32'h00100093);
    end

    // Oversize count, then empty program
    apply_reset();
    do_start(9'd257);
    check("ovf_error",  32'(error),      32'd1);
    check("ovf_creset", 32'(core_reset), 32'd1);
    check("ovf_ready",  32'(in_ready),   32'd0);
    repeat (3) @(negedge clk);
    check("ovf_idle_ready", 32'(in_ready), 32'd0);
    check("ovf_writes", 32'(wr_addr.size()), 32'd0);
    do_start(9'd0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
    @(negedge clk);
`endif
    check("zero_done",   32'(done),       32'd1);
    check("zero_creset", 32'(core_reset), 32'd0);

    // Reset in the middle of word 1
    apply_reset();
    do_start(9'd2);
    for (int i = 0; i < 6; i++) send_byte(prog[i]);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready",  32'(in_ready),   32'd0);
    check("mid_rst_we",     32'(imem_we),    32'd0);
    check("mid_rst_addr",   32'(imem_addr),  32'd0);
    check("mid_rst_wdata",  imem_wdata,      32'd0);
    check("mid_rst_creset", 32'(core_reset), 32'd1);
    check("mid_rst_done",   32'(done),       32'd0);
    check("mid_rst_error",  32'(error),      32'd0);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    do_start(9'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_done(done_cyc);
    check("fresh_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("fresh_addr", 32'(wr_addr[0]), 32'd0);
      check("fresh_data", wr_data[0],      32'hDDCCBBAA);
    end

`ifdef BOOT_CHECKSUM_EN
    // Checksum match
    apply_reset();
    do_start(9'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    check("cks_ready_in_check", 32'(in_ready), 32'd0);
    send_byte(8'h0F);
    @(negedge clk);
    check("cks_ok_done",   32'(done),       32'd1);
    check("cks_ok_creset", 32'(core_reset), 32'd0);
    check("cks_ok_error",  32'(error),      32'd0);
    if (wr_addr.size() == 1) check("cks_data", wr_data[0], 32'h08040201);
    else check("cks_nwrites", 32'(wr_addr.size()), 32'd1);

    // Checksum mismatch
    apply_reset();
    do_start(9'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0E);
    repeat (2) @(negedge clk);
    check("cks_bad_error",  32'(error),      32'd1);
    check("cks_bad_done",   32'(done),       32'd0);
    check("cks_bad_creset", 32'(core_reset), 32'd1);
    check("cks_bad_ready",  32'(in_ready),   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
